sram_1p_march_bist_ctrl: RTL and testbench

//  Parametrised March C- BIST engine driving the A_BIST_* port of any IHP SG13G2 1P SRAM macro (byte-mask/BIST variants).

---
 rtl/sram_1p_march_bist_ctrl_pkg.sv | 29 ++
 rtl/sram_1p_march_bist_ctrl_if.sv | 35 +++
 rtl/sram_1p_march_bist_ctrl_addr_gen.sv | 24 ++
 rtl/sram_1p_march_bist_ctrl.sv | 139 +++++++++++++
 tb/tb_sram_1p_march_bist_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_1p_march_bist_ctrl_pkg.sv
// Shared types for the SRAM March C- BIST engine: FSM state encoding and the march element table.
package sram_bist_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_e;

  // One march element: address direction, which ops it carries, read-expect and write background.
  typedef struct packed {
    logic down;
    logic has_rd;
    logic has_wr;
    logic rd_val;
    logic wr_val;
  } march_elem_t;

  // Indexed by state_e; non-march states carry an all-zero element (up, no ops).
  localparam march_elem_t MARCH_TBL [16] = '{
    '0,                                    // IDLE
    '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0},       // M0 up(w0)
    '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1},       // M1 up(r0,w1)
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},       // M2 up(r1,w0)
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1},       // M3 down(r0,w1)
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},       // M4 down(r1,w0)
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},       // M5 up(r0)
    '0, '0, '0, '0, '0, '0, '0, '0, '0
  };

endpackage

// File: rtl/sram_1p_march_bist_ctrl_if.sv
// Control/result and macro BIST-port signals of the March BIST engine.
interface sram_1p_march_bist_ctrl_if #(
  parameter int P_ADDR_WIDTH = 12,
  parameter int P_DATA_WIDTH = 8
);
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic                    fail;
  logic [P_ADDR_WIDTH-1:0] fail_addr;
  logic [P_DATA_WIDTH-1:0] fail_data;
  logic                    A_BIST_EN;
  logic                    A_BIST_MEN;
  logic                    A_BIST_WEN;
  logic                    A_BIST_REN;
  logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR;
  logic [P_DATA_WIDTH-1:0] A_BIST_DIN;
  logic [P_DATA_WIDTH-1:0] A_BIST_BM;
  logic [P_DATA_WIDTH-1:0] A_DOUT;

  modport master (
    input  start, A_DOUT,
    output busy, done, pass, fail, fail_addr, fail_data,
           A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
           A_BIST_ADDR, A_BIST_DIN, A_BIST_BM
  );

  modport slave (
    output start, A_DOUT,
    input  busy, done, pass, fail, fail_addr, fail_data,
           A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
           A_BIST_ADDR, A_BIST_DIN, A_BIST_BM
  );
endinterface

// File: rtl/sram_1p_march_bist_ctrl_addr_gen.sv
// Loadable up/down address counter; o_tc flags the last address of the current direction.
module sram_bist_addr_gen #(
  parameter int P_ADDR_WIDTH = 12
) (
  input  logic                    A_CLK,
  input  logic                    A_RST,
  input  logic                    i_load,
  input  logic                    i_load_down,
  input  logic                    i_step,
  input  logic                    i_down,
  output logic [P_ADDR_WIDTH-1:0] o_addr,
  output logic                    o_tc
);
  logic [P_ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST)       r_addr <= '0;
    else if (i_load) r_addr <= i_load_down ? '1 : '0;
    else if (i_step) r_addr <= i_down ? r_addr - 1'b1 : r_addr + 1'b1;
  end

  assign o_addr = r_addr;
  assign o_tc   = i_down ? (r_addr == '0) : (r_addr == '1);
endmodule

// File: rtl/sram_1p_march_bist_ctrl.sv
// March C- BIST engine for a 1P SRAM macro BIST port: FSM, pipelined read compare, result flags.
// Optional SRAM_BIST_FAIL_LOG_EN captures address/data of the first mismatch.
module sram_1p_march_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 12,
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                       A_CLK,
  input  logic                       A_RST,
  sram_1p_march_bist_ctrl_if.master  bus
);
  state_e                  r_state, w_nxt_state;
  logic                    r_ph, w_nxt_ph;
  logic                    w_load, w_step, w_tc, w_start;
  logic                    w_nxt_op, w_nxt_rd, w_nxt_wr, w_nxt_busy;
  logic [P_ADDR_WIDTH-1:0] w_addr;
  logic                    r_busy, r_men, r_wen, r_done, r_pass, r_fail, r_exp;
  logic [1:0]              r_vld_pipe;
  logic [P_DATA_WIDTH-1:0] r_din, r_bm;
  logic                    w_mis;

  assign w_start = bus.start && (r_state == S_IDLE || r_state == S_DONE);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ph    = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (bus.start) begin
        w_nxt_state = S_M0;
        w_load      = 1'b1;
      end
      S_DRAIN: w_nxt_state = S_DONE;
      default: begin
        // Two-op elements spend a read then a write cycle on the same address.
        if (MARCH_TBL[r_state].has_rd && MARCH_TBL[r_state].has_wr && !r_ph)
          w_nxt_ph = 1'b1;
        else if (w_tc) begin
          w_nxt_state = state_e'(r_state + 4'd1);
          w_load      = 1'b1;
        end else
          w_step = 1'b1;
      end
    endcase
  end

  assign w_nxt_op   = w_nxt_state inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5};
  assign w_nxt_rd   = w_nxt_op && MARCH_TBL[w_nxt_state].has_rd && !w_nxt_ph;
  assign w_nxt_wr   = w_nxt_op && MARCH_TBL[w_nxt_state].has_wr && !w_nxt_rd;
  assign w_nxt_busy = w_nxt_op || (w_nxt_state == S_DRAIN);

  sram_bist_addr_gen #(.P_ADDR_WIDTH(P_ADDR_WIDTH)) u_addr (
    .A_CLK       (A_CLK),
    .A_RST       (A_RST),
    .i_load      (w_load),
    .i_load_down (MARCH_TBL[w_nxt_state].down),
    .i_step      (w_step),
    .i_down      (MARCH_TBL[r_state].down),
    .o_addr      (w_addr),
    .o_tc        (w_tc)
  );

  // Stage 1 of the valid pipe is the cycle A_DOUT holds the read issued one cycle earlier.
  assign w_mis = r_vld_pipe[1] && (bus.A_DOUT != {P_DATA_WIDTH{r_exp}});

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      r_state    <= S_IDLE;
      r_ph       <= 1'b0;
      r_busy     <= 1'b0;
      r_men      <= 1'b0;
      r_wen      <= 1'b0;
      r_vld_pipe <= '0;
      r_din      <= '0;
      r_bm       <= '0;
      r_exp      <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_ph       <= w_nxt_ph;
      r_busy     <= w_nxt_busy;
      r_men      <= w_nxt_op;
      r_wen      <= w_nxt_wr;
      r_vld_pipe <= {r_vld_pipe[0], w_nxt_rd};
      r_din      <= {P_DATA_WIDTH{w_nxt_wr && MARCH_TBL[w_nxt_state].wr_val}};
      r_bm       <= {P_DATA_WIDTH{w_nxt_busy}};
      r_exp      <= MARCH_TBL[r_state].rd_val;
      r_done     <= (w_nxt_state == S_DONE);
      // Entering DONE also folds in the compare of the final M5 read.
      r_pass     <= (w_nxt_state == S_DONE) && !(r_fail || w_mis);
      if (w_start)    r_fail <= 1'b0;
      else if (w_mis) r_fail <= 1'b1;
    end
  end

`ifdef SRAM_BIST_FAIL_LOG_EN
  logic [P_ADDR_WIDTH-1:0] r_cmp_addr, r_fail_addr;
  logic [P_DATA_WIDTH-1:0] r_fail_data;

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      r_cmp_addr  <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_cmp_addr <= w_addr;
      if (w_start) begin
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else if (w_mis && !r_fail) begin
        r_fail_addr <= r_cmp_addr;
        r_fail_data <= bus.A_DOUT;
      end
    end
  end

  assign bus.fail_addr = r_fail_addr;
  assign bus.fail_data = r_fail_data;
`else
  assign bus.fail_addr = '0;
  assign bus.fail_data = '0;
`endif

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.fail        = r_fail;
  assign bus.A_BIST_EN   = r_busy;
  assign bus.A_BIST_MEN  = r_men;
  assign bus.A_BIST_WEN  = r_wen;
  assign bus.A_BIST_REN  = r_vld_pipe[0];
  assign bus.A_BIST_ADDR = w_addr;
  assign bus.A_BIST_DIN  = r_din;
  assign bus.A_BIST_BM   = r_bm;
endmodule

// File: tb/tb_sram_1p_march_bist_ctrl.sv
// Bench for the March C- BIST engine: faulty SRAM model, algorithmic march reference, random faults.
module tb_sram_1p_march_bist_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 16;

  logic A_CLK = 1'b0;
  logic A_RST = 1'b0;
  always #5 A_CLK = ~A_CLK;

  sram_1p_march_bist_ctrl_if #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) bus();

  sram_1p_march_bist_ctrl #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) dut (
    .A_CLK (A_CLK),
    .A_RST (A_RST),
    .bus   (bus.master)
  );

  // Fault configuration: one stuck-at cell and one write-triggered inversion coupling.
  int          sa_addr = -1;
  logic [DW-1:0] sa1 = '0, sa0 = '0;
  bit          cf_en = 1'b0;
  int          cf_agg = 0, cf_vic = 0;

  function automatic logic [DW-1:0] rd_fault(input int a, input logic [DW-1:0] v);
    return (a == sa_addr) ? ((v & ~sa0) | sa1) : v;
  endfunction

  logic [DW-1:0] mem [N];
  always @(posedge A_CLK) begin
    if (bus.A_BIST_EN && bus.A_BIST_MEN) begin
      if (bus.A_BIST_REN)
        bus.A_DOUT <= rd_fault(int'(bus.A_BIST_ADDR), mem[bus.A_BIST_ADDR]);
      if (bus.A_BIST_WEN) begin
        mem[bus.A_BIST_ADDR] = (mem[bus.A_BIST_ADDR] & ~bus.A_BIST_BM) | (bus.A_BIST_DIN & bus.A_BIST_BM);
        if (cf_en && int'(bus.A_BIST_ADDR) == cf_agg) mem[cf_vic] = ~mem[cf_vic];
      end
    end
  end

  // Reference: expected op stream and first-mismatch outcome, straight from the March C- recipe.
  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] din; } op_t;
  op_t           exp_ops [10*N];
  int            n_exp;
  bit            exp_fail;
  logic [AW-1:0] exp_faddr;
  logic [DW-1:0] exp_fdata;

  task automatic ref_model();
    logic [DW-1:0] m [N];
    bit el_down [6] = '{0, 0, 0, 1, 1, 0};
    int el_rd   [6] = '{-1, 0, 1, 0, 1, 0};
    int el_wr   [6] = '{0, 1, 0, 1, 0, -1};
    int k = 0;
    logic [DW-1:0] got, want;
    exp_fail = 0; exp_faddr = '0; exp_fdata = '0;
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        a = el_down[e] ? N - 1 - i : i;
        if (el_rd[e] >= 0) begin
          got  = rd_fault(a, m[a]);
          want = (el_rd[e] == 1) ? {DW{1'b1}} : {DW{1'b0}};
          exp_ops[k] = '{1'b0, AW'(a), '0}; k++;
          if (got != want && !exp_fail) begin
            exp_fail = 1; exp_faddr = AW'(a); exp_fdata = got;
          end
        end
        if (el_wr[e] >= 0) begin
          m[a] = (el_wr[e] == 1) ? {DW{1'b1}} : {DW{1'b0}};
          exp_ops[k] = '{1'b1, AW'(a), m[a]}; k++;
          if (cf_en && a == cf_agg) m[cf_vic] = ~m[cf_vic];
        end
      end
    end
    n_exp = k;
  endtask

  // Bus monitor: op stream against the reference and the port protocol rules.
  int op_idx = 0, run_ops = 0, seq_err = 0, viol = 0;
  bit prev_busy = 0;
  always @(negedge A_CLK) begin
    if (bus.busy && !prev_busy) begin op_idx = 0; run_ops = 0; end
    prev_busy = bus.busy;
    if (bus.A_BIST_WEN && bus.A_BIST_REN) viol++;
    if (bus.A_BIST_EN != bus.busy) viol++;
    if (bus.A_BIST_BM != {DW{bus.busy}}) viol++;
    if (bus.A_BIST_MEN && !bus.busy) viol++;
    if (bus.A_BIST_MEN) begin
      if (bus.A_BIST_WEN == bus.A_BIST_REN) viol++;
      if (op_idx >= n_exp) seq_err++;
      else if (bus.A_BIST_WEN != exp_ops[op_idx].we || bus.A_BIST_ADDR != exp_ops[op_idx].addr ||
               (exp_ops[op_idx].we && bus.A_BIST_DIN != exp_ops[op_idx].din)) seq_err++;
      op_idx++; run_ops++;
    end
  end

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {24'd0, bus.busy, bus.done, bus.pass, bus.fail, bus.fail_addr, bus.fail_data,
            bus.A_BIST_EN, bus.A_BIST_MEN, bus.A_BIST_WEN, bus.A_BIST_REN,
            bus.A_BIST_ADDR, bus.A_BIST_DIN, bus.A_BIST_BM};
  endfunction

  function automatic logic [AW-1:0] log_addr(input logic [AW-1:0] a);
`ifdef SRAM_BIST_FAIL_LOG_EN
    return a;
`else
    return '0;
`endif
  endfunction

  function automatic logic [DW-1:0] log_data(input logic [DW-1:0] d);
`ifdef SRAM_BIST_FAIL_LOG_EN
    return d;
`else
    return '0;
`endif
  endfunction

  // Pulse start, wait for done, check timing, result and logged failure.
  task automatic kick();
    @(posedge A_CLK); #1 bus.start = 1'b1;
    @(posedge A_CLK); #1 bus.start = 1'b0;
  endtask

  task automatic run(input string tag, input int mid);
    int cyc = 0, nbusy = 0, s0, v0;
    ref_model();
    s0 = seq_err; v0 = viol;
    kick();
    while (cyc < 400 && !bus.done) begin
      @(negedge A_CLK);
      cyc++;
      if (bus.busy) nbusy++;
      if (cyc == 1) begin
        chk({tag, ".clr_fail"}, 64'(bus.fail), 64'd0);
        chk({tag, ".clr_flog"}, 64'({bus.fail_addr, bus.fail_data}), 64'd0);
      end
      bus.start = (cyc == mid);
    end
    bus.start = 1'b0;
    chk({tag, ".done_cyc"}, 64'(cyc), 64'(10*N + 2));
    chk({tag, ".busy_cyc"}, 64'(nbusy), 64'(10*N + 1));
    chk({tag, ".pass"}, 64'(bus.pass), 64'(!exp_fail));
    chk({tag, ".fail"}, 64'(bus.fail), 64'(exp_fail));
    chk({tag, ".fail_addr"}, 64'(bus.fail_addr), 64'(log_addr(exp_faddr)));
    chk({tag, ".fail_data"}, 64'(bus.fail_data), 64'(log_data(exp_fdata)));
    chk({tag, ".ops"}, 64'(run_ops), 64'(n_exp));
    chk({tag, ".seq"}, 64'(seq_err - s0), 64'd0);
    chk({tag, ".proto"}, 64'(viol - v0), 64'd0);
    repeat (2) @(negedge A_CLK);
    chk({tag, ".hold"}, 64'({bus.done, bus.busy, bus.A_BIST_EN, bus.pass}), 64'({1'b1, 1'b0, 1'b0, !exp_fail}));
  endtask

  task automatic clear_faults();
    sa_addr = -1; sa1 = '0; sa0 = '0; cf_en = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    A_RST = 1'b1;
    #12;
    chk("reset_outs", all_outs(), 64'd0);
    #10 A_RST = 1'b0;

    run("clean", 0);

    sa_addr = 5; sa1 = 8'h08;
    run("sa1_a5b3", 0);

    clear_faults();
    cf_en = 1'b1; cf_agg = 9; cf_vic = 2;
    run("cf_9to2", 0);

    clear_faults();
    run("mid_start", 50);

    // Reset in the middle of a run, then a full clean run.
    ref_model();
    kick();
    repeat (80) @(negedge A_CLK);
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    #2 A_RST = 1'b1;
    #1 chk("rst_mid_outs", all_outs(), 64'd0);
    #10 A_RST = 1'b0;
    run("post_rst", 0);

    for (int it = 0; it < 6; it++) begin
      int kind, b;
      clear_faults();
      kind = int'($urandom_range(0, 2));
      if (kind == 1) begin
        sa_addr = int'($urandom_range(0, N - 1));
        b = int'($urandom_range(0, DW - 1));
        if ($urandom_range(0, 1) == 1) sa1 = DW'(1 << b);
        else                           sa0 = DW'(1 << b);
      end else if (kind == 2) begin
        cf_en  = 1'b1;
        cf_agg = int'($urandom_range(0, N - 1));
        cf_vic = (cf_agg + int'($urandom_range(1, N - 1))) % N;
      end
      run($sformatf("rnd%0d_k%0d", it, kind), ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 150)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
